// File: rtl/day10_min_press_solver.sv
// Minimum-press solver for one Day 10 machine: streams in a target and button masks,
// walks all button subsets in Gray-code order and accumulates per-machine results.
module day10_min_press_solver #(
    parameter int MAX_NUM_BUTTONS   = 16,
    parameter int MAX_NUM_LIGHTS    = 10,
    parameter int MAX_NUM_BUTTONS_W = (MAX_NUM_BUTTONS <= 1) ? 1 : $clog2(MAX_NUM_BUTTONS + 1),
    parameter int MAX_NUM_PRESSES_W = MAX_NUM_BUTTONS_W,
    parameter int TOTAL_W           = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         hdr_valid,
    output logic                         hdr_ready,
    input  logic [MAX_NUM_LIGHTS-1:0]    hdr_target,
    input  logic [MAX_NUM_BUTTONS_W-1:0] hdr_num_buttons,
    input  logic                         btn_valid,
    output logic                         btn_ready,
    input  logic [MAX_NUM_LIGHTS-1:0]    btn_mask,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_solvable,
    output logic [MAX_NUM_PRESSES_W-1:0] min_button_presses,
    output logic [MAX_NUM_BUTTONS-1:0]   buttons_to_press,
    input  logic                         clear_totals,
    output logic [TOTAL_W-1:0]           total_presses,
    output logic [TOTAL_W-1:0]           total_machines
);
    localparam int NB = MAX_NUM_BUTTONS;
    localparam int NL = MAX_NUM_LIGHTS;
    localparam int BW = MAX_NUM_BUTTONS_W;
    localparam int PW = MAX_NUM_PRESSES_W;

    typedef enum logic [1:0] {IDLE, LOAD, SEARCH, DONE} state_t;

    state_t        state;
    logic [NL-1:0] target;
    logic [NL-1:0] acc;
    logic [NL-1:0] masks [NB];
    logic [BW-1:0] n;
    logic [BW-1:0] idx;
    logic [NB-1:0] k;
    logic [NB-1:0] subset;
    logic [NB-1:0] best_set;
    logic [PW-1:0] pc;
    logic [PW-1:0] best;
    logic          found;

    logic [BW-1:0] hdr_n;
    logic [NB-1:0] next_k;
    logic [NB-1:0] low_bit;
    logic [NB-1:0] last_k;
    logic [NB-1:0] step_subset;
    logic [NL-1:0] step_mask;
    logic [NL-1:0] step_acc;
    logic [PW-1:0] step_pc;
    logic          hit;

    // The lowest set bit of the next Gray index is the single button that toggles.
    always_comb begin
        hdr_n     = (hdr_num_buttons > BW'(NB)) ? BW'(NB) : hdr_num_buttons;
        next_k    = k + NB'(1);
        low_bit   = next_k & (~next_k + NB'(1));
        last_k    = (NB'(1) << n) - NB'(1);
        step_mask = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            if (low_bit[i]) step_mask = step_mask | masks[i];
        end
        step_acc    = acc ^ step_mask;
        step_subset = subset ^ low_bit;
        step_pc     = ((subset & low_bit) != '0) ? pc - PW'(1) : pc + PW'(1);
        hit         = (step_acc == target) && (!found || (step_pc < best));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            hdr_ready          <= 1'b1;
            btn_ready          <= 1'b0;
            out_valid          <= 1'b0;
            out_solvable       <= 1'b0;
            min_button_presses <= '0;
            buttons_to_press   <= '0;
            target             <= '0;
            acc                <= '0;
            n                  <= '0;
            idx                <= '0;
            k                  <= '0;
            subset             <= '0;
            best_set           <= '0;
            pc                 <= '0;
            best               <= '0;
            found              <= 1'b0;
            for (int unsigned i = 0; i < NB; i++) masks[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hdr_valid && hdr_ready) begin
                        target    <= hdr_target;
                        n         <= hdr_n;
                        idx       <= '0;
                        best      <= '0;
                        best_set  <= '0;
                        found     <= 1'b0;
                        hdr_ready <= 1'b0;
                        for (int unsigned i = 0; i < NB; i++) masks[i] <= '0;
                        if (hdr_n == '0) begin
                            state              <= DONE;
                            out_valid          <= 1'b1;
                            out_solvable       <= (hdr_target == '0);
                            min_button_presses <= '0;
                            buttons_to_press   <= '0;
                        end else begin
                            state     <= LOAD;
                            btn_ready <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (btn_valid && btn_ready) begin
                        for (int unsigned i = 0; i < NB; i++) begin
                            if (idx == BW'(i)) masks[i] <= btn_mask;
                        end
                        idx <= idx + BW'(1);
                        if (idx == n - BW'(1)) begin
                            state     <= SEARCH;
                            btn_ready <= 1'b0;
                            k         <= '0;
                            acc       <= '0;
                            subset    <= '0;
                            pc        <= '0;
                            best      <= '0;
                            best_set  <= '0;
                            found     <= (target == '0);
                        end
                    end
                end
                SEARCH: begin
                    k      <= next_k;
                    acc    <= step_acc;
                    subset <= step_subset;
                    pc     <= step_pc;
                    if (hit) begin
                        best     <= step_pc;
                        best_set <= step_subset;
                        found    <= 1'b1;
                    end
                    // The final step's hit is folded straight into the published result.
                    if (next_k == last_k) begin
                        state              <= DONE;
                        out_valid          <= 1'b1;
                        out_solvable       <= found | hit;
                        min_button_presses <= hit ? step_pc : best;
                        buttons_to_press   <= hit ? step_subset : best_set;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        hdr_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_presses  <= '0;
            total_machines <= '0;
        end else if (clear_totals) begin
            total_presses  <= '0;
            total_machines <= '0;
        end else if (out_valid && out_ready) begin
            total_machines <= total_machines + TOTAL_W'(1);
            if (out_solvable) total_presses <= total_presses + TOTAL_W'(min_button_presses);
        end
    end
endmodule

// File: tb/tb_day10_min_press_solver.sv
// Directed bench for day10_min_press_solver: AoC example machines, boundary cases,
// stalls, clear/handshake collision and mid-search reset.
module tb_day10_min_press_solver;
    localparam int NB = 16;
    localparam int NL = 10;
    localparam int BW = 5;
    localparam int TW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          hdr_valid = 1'b0;
    logic          hdr_ready;
    logic [NL-1:0] hdr_target = '0;
    logic [BW-1:0] hdr_num_buttons = '0;
    logic          btn_valid = 1'b0;
    logic          btn_ready;
    logic [NL-1:0] btn_mask = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_solvable;
    logic [BW-1:0] min_button_presses;
    logic [NB-1:0] buttons_to_press;
    logic          clear_totals = 1'b0;
    logic [TW-1:0] total_presses;
    logic [TW-1:0] total_machines;

    day10_min_press_solver #(
        .MAX_NUM_BUTTONS(NB),
        .MAX_NUM_LIGHTS(NL),
        .TOTAL_W(TW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .hdr_valid(hdr_valid),
        .hdr_ready(hdr_ready),
        .hdr_target(hdr_target),
        .hdr_num_buttons(hdr_num_buttons),
        .btn_valid(btn_valid),
        .btn_ready(btn_ready),
        .btn_mask(btn_mask),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_solvable(out_solvable),
        .min_button_presses(min_button_presses),
        .buttons_to_press(buttons_to_press),
        .clear_totals(clear_totals),
        .total_presses(total_presses),
        .total_machines(total_machines)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int unsigned cyc = 0;
    int unsigned hdr_cyc = 0;
    int          lat = 0;
    int          exp_p = 0;
    int          exp_m = 0;
    logic [NL-1:0] mq [NB];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_machine(input logic [NL-1:0] tgt, input int n, input bit gaps);
        int cnt;
        hdr_target      = tgt;
        hdr_num_buttons = BW'(n);
        hdr_valid       = 1'b1;
        cnt = 0;
        while (!hdr_ready && cnt < 20) begin @(negedge clk); cnt++; end
        chk("hdr_ready_idle", hdr_ready, 1);
        hdr_cyc = cyc;
        @(negedge clk);
        hdr_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (gaps && (i % 2 == 1)) begin
                btn_valid = 1'b0;
                btn_mask  = '1;
                @(negedge clk);
            end
            btn_valid = 1'b1;
            btn_mask  = mq[i];
            cnt = 0;
            while (!btn_ready && cnt < 20) begin @(negedge clk); cnt++; end
            chk("btn_ready_load", btn_ready, 1);
            @(negedge clk);
        end
        btn_valid = 1'b0;
        btn_mask  = '0;
    endtask

    task automatic wait_done();
        int cnt;
        cnt = 0;
        while (!out_valid && cnt < 500) begin @(negedge clk); cnt++; end
        chk("out_valid_done", out_valid, 1);
        lat = int'(cyc - hdr_cyc);
    endtask

    task automatic check_result(input string tag, input logic solv, input int mn, input logic [NB-1:0] set);
        chk({tag, "_solvable"}, out_solvable, solv);
        chk({tag, "_min"}, min_button_presses, mn);
        chk({tag, "_set"}, buttons_to_press, set);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid_after_take", out_valid, 0);
        chk("hdr_ready_after_take", hdr_ready, 1);
        chk("total_presses", total_presses, exp_p);
        chk("total_machines", total_machines, exp_m);
    endtask

    task automatic set_m1();
        mq[0] = 10'b0000001000; mq[1] = 10'b0000001010; mq[2] = 10'b0000000100;
        mq[3] = 10'b0000001100; mq[4] = 10'b0000000101; mq[5] = 10'b0000000011;
    endtask
    task automatic set_m2();
        mq[0] = 10'b0000011101; mq[1] = 10'b0000001100; mq[2] = 10'b0000010001;
        mq[3] = 10'b0000000111; mq[4] = 10'b0000011110;
    endtask
    task automatic set_m3();
        mq[0] = 10'b0000011111; mq[1] = 10'b0000011001; mq[2] = 10'b0000110111;
        mq[3] = 10'b0000000110;
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        chk("rst_hdr_ready", hdr_ready, 1);
        chk("rst_btn_ready", btn_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        check_result("rst", 1'b0, 0, '0);
        chk("rst_total_presses", total_presses, 0);
        chk("rst_total_machines", total_machines, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // AoC machine 1: b1^b3 precedes b4^b5 in Gray order
        set_m1();
        start_machine(10'b0000000110, 6, 1'b0);
        wait_done();
        chk("m1_latency", lat, 70);
        check_result("m1", 1'b1, 2, 16'b001010);
        exp_p = 2; exp_m = 1;
        consume();

        // AoC machine 2: only b2^b3^b4 hits target
        set_m2();
        start_machine(10'b0000001000, 5, 1'b0);
        wait_done();
        chk("m2_latency", lat, 5 + 31 + 1);
        check_result("m2", 1'b1, 3, 16'b11100);
        exp_p = 5; exp_m = 2;
        consume();

        // AoC machine 3: b1^b2
        set_m3();
        start_machine(10'b0000101110, 4, 1'b0);
        wait_done();
        check_result("m3", 1'b1, 2, 16'b0110);
        exp_p = 7; exp_m = 3;
        consume();

        // Zero target: empty subset wins over b0^b1^b2
        mq[0] = 10'b0000000001; mq[1] = 10'b0000000010; mq[2] = 10'b0000000011;
        start_machine(10'b0000000000, 3, 1'b0);
        wait_done();
        check_result("zero_tgt", 1'b1, 0, '0);
        exp_m = 4;
        consume();

        // No buttons, nonzero target: unsolvable, one-cycle latency
        start_machine(10'b0000000001, 0, 1'b0);
        wait_done();
        chk("n0_latency", lat, 1);
        check_result("n0", 1'b0, 0, '0);
        exp_m = 5;
        consume();

        // Gapped load plus 10-cycle output stall
        set_m3();
        start_machine(10'b0000101110, 4, 1'b1);
        wait_done();
        check_result("gap", 1'b1, 2, 16'b0110);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_out_valid", out_valid, 1);
            chk("stall_min", min_button_presses, 2);
            chk("stall_set", buttons_to_press, 16'b0110);
            chk("stall_hdr_ready", hdr_ready, 0);
            chk("stall_total_presses", total_presses, exp_p);
        end
        exp_p = 9; exp_m = 6;
        consume();

        // clear_totals coinciding with the out handshake
        set_m2();
        start_machine(10'b0000001000, 5, 1'b0);
        wait_done();
        check_result("clr", 1'b1, 3, 16'b11100);
        out_ready    = 1'b1;
        clear_totals = 1'b1;
        @(negedge clk);
        out_ready    = 1'b0;
        clear_totals = 1'b0;
        chk("clr_total_presses", total_presses, 0);
        chk("clr_total_machines", total_machines, 0);
        chk("clr_hdr_ready", hdr_ready, 1);
        exp_p = 0; exp_m = 0;

        // Accumulation resumes after a clear
        set_m1();
        start_machine(10'b0000000110, 6, 1'b0);
        wait_done();
        check_result("post_clr", 1'b1, 2, 16'b001010);
        exp_p = 2; exp_m = 1;
        consume();

        // Reset pulsed mid-search
        set_m1();
        start_machine(10'b0000000110, 6, 1'b0);
        repeat (10) @(negedge clk);
        chk("pre_rst_out_valid", out_valid, 0);
        chk("pre_rst_hdr_ready", hdr_ready, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_hdr_ready", hdr_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_total_presses", total_presses, 0);
        chk("midrst_total_machines", total_machines, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (80) @(negedge clk);
        chk("post_rst_out_valid", out_valid, 0);
        chk("post_rst_hdr_ready", hdr_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/day10_min_press_solver.md
Name: day10_min_press_solver

Overview:
- Sequential solver for one Day 10 machine at a time: given a target light pattern and up to MAX_NUM_BUTTONS toggle masks, finds the minimum-cardinality button subset whose XOR equals the target.
- Enumerates subsets in Gray-code order: one XOR and one popcount update per cycle.
- Keeps running totals across machines for the part-1 answer.
- Successor to the plain day10 output bundle: adds light-width parametrisation, streamed loading, a solvable flag, a tie-break rule and accumulation.

Parameters:
MAX_NUM_BUTTONS, 16, maximum buttons per machine; search depth is 2^MAX_NUM_BUTTONS
MAX_NUM_LIGHTS, 10, number of indicator lights; width of target and button masks
MAX_NUM_BUTTONS_W, clog2(MAX_NUM_BUTTONS+1) (1 if MAX_NUM_BUTTONS<=1), width of the button count
MAX_NUM_PRESSES_W, MAX_NUM_BUTTONS_W, width of the press count
TOTAL_W, 32, width of the running totals

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
hdr_valid  input  1  machine header valid
hdr_ready  output  1  header accepted when hdr_valid & hdr_ready
hdr_target  input  MAX_NUM_LIGHTS  target pattern; bit i = light i on
hdr_num_buttons  input  MAX_NUM_BUTTONS_W  buttons that follow (0..MAX_NUM_BUTTONS)
btn_valid  input  1  button mask valid
btn_ready  output  1  mask accepted on handshake
btn_mask  input  MAX_NUM_LIGHTS  lights toggled by this button, in button order
out_valid  output  1  result valid
out_ready  input  1  result consumed on handshake
out_solvable  output  1  a solution exists
min_button_presses  output  MAX_NUM_PRESSES_W  minimum presses (0 if unsolvable)
buttons_to_press  output  MAX_NUM_BUTTONS  chosen subset; bit j = press button j (0 if unsolvable)
clear_totals  input  1  synchronous clear of the totals
total_presses  output  TOTAL_W  sum of min_button_presses over solvable machines
total_machines  output  TOTAL_W  count of results consumed, including unsolvable

Behaviour:
- Reset (async assert, sync deassert):
  - State IDLE.
  - All outputs 0 except hdr_ready=1.
  - Mask storage, search registers and totals cleared.
- FSM:
  - IDLE: hdr_ready=1.
    - On header handshake: latch target and n = min(hdr_num_buttons, MAX_NUM_BUTTONS); zero all stored masks.
    - If n=0, go to DONE next cycle; otherwise go to LOAD.
  - LOAD: btn_ready=1.
    - Each handshake stores btn_mask into slot idx, then increments idx.
    - After slot n-1 is stored: go to SEARCH.
    - Init: k=0, acc=0, pc=0.
    - Empty-subset check: if target==0, best=0, best_set=0, found=1.
  - SEARCH: one step per cycle for k=1..2^n-1.
    - j = count-trailing-zeros(k).
    - acc ^= mask[j]; bit j of the current subset toggles; pc +=1 if the bit was set, -=1 if cleared.
    - If acc==target and (!found or pc<best): best=pc, best_set=current subset, found=1.
    - Strict less-than, so the first minimum in Gray order wins.
    - After k=2^n-1: go to DONE.
    - Exactly 2^n-1 SEARCH cycles.
  - DONE: out_valid=1.
    - Outputs held stable until the out handshake; on it, return to IDLE.
    - Ready handshakes are not taken outside their own state; hdr_ready=btn_ready=0 in SEARCH and DONE.
- Totals:
  - On out handshake: total_machines += 1; total_presses += min_button_presses if solvable.
  - Totals wrap modulo 2^TOTAL_W.
  - clear_totals zeroes both; if it coincides with an out handshake, clear wins and that result is not added.
  - clear_totals does not disturb the FSM.
- Latency, header handshake to out_valid:
  - n>0: n mask cycles (back-to-back) + 2^n-1 search cycles + 1.
  - n=0: 1 cycle.
- Bit 0 of every mask and subset is button 0 / light 0. Mask slots >= n are don't-care and never selected. buttons_to_press bits >= n are 0.
- hdr_num_buttons > MAX_NUM_BUTTONS is illegal; the block clamps it and the source must not send the excess masks.
- Reset mid-search or mid-load aborts the machine; the totals are lost.

Test Plan:
- Target 0110, n=6, masks 1000, 1010, 0100, 1100, 0101, 0011 -> out_solvable=1, min=2, buttons_to_press=6'b001010 (b1^b3 found before b4^b5 in Gray order); out_valid exactly 6+63+1 cycles after the header.
- Full AoC 2025 day 10 example (three machines, out_ready=1) -> per-machine min 2, 3, 2; total_presses=7, total_machines=3.
- Target 0000 with n=3 nonzero masks -> min=0, buttons_to_press=0, solvable=1; n=0 with target 0001 -> solvable=0, min=0, total_machines+1 and total_presses unchanged.
- Stall: out_ready=0 for 10 cycles in DONE -> outputs stable, hdr_ready=0, totals unchanged; btn_valid gaps in LOAD -> identical result.
- clear_totals asserted in the out-handshake cycle -> both totals 0 next cycle; rst_n pulsed mid-SEARCH -> IDLE, hdr_ready=1, out_valid=0, totals 0.
